// File: rtl/tlc_pkg.sv
// Shared lamp codes, phase encodings and round-robin grant helper for the traffic controller.
// Latency: n/a (combinational helpers only).  Backpressure: n/a.
// Lamp and phase codes here are the external encodings seen on lights/phase.
package tlc_pkg;

  localparam logic [1:0] LAMP_GREEN  = 2'b00;
  localparam logic [1:0] LAMP_YELLOW = 2'b01;
  localparam logic [1:0] LAMP_RED    = 2'b10;

  typedef enum logic [1:0] {
    PH_GREEN  = 2'd0,
    PH_YELLOW = 2'd1,
    PH_ALLRED = 2'd2,
    PH_WALK   = 2'd3
  } phase_e;

  // First requesting direction after cur (wrapping); cur+1 when nobody else requests.
  function automatic logic [2:0] rr_next(input logic [7:0] req, input logic [2:0] cur, input int n);
    logic [2:0] res;
    logic       found;
    int         idx;
    res   = 3'((int'(cur) + 1) % n);
    found = 1'b0;
    for (int i = 1; i < 8; i++) begin
      idx = (int'(cur) + i) % n;
      if (!found && i < n && req[idx[2:0]]) begin
        res   = idx[2:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/tlc_phase_timer.sv
// Phase timer: synchronous clear, increment, saturate at SAT.
// Latency: count visible one cycle after the edge.  Backpressure: none.
module tlc_phase_timer #(
  parameter int W   = 5,
  parameter int SAT = 15
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != W'(SAT)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/traffic_ctrl_multi.sv
// Round-robin Moore traffic-light controller for NUM_DIR approaches; optional walk phase via TLC_PED_EN.
// Latency: lamps decoded from registers only, change one cycle after the deciding edge.
// Backpressure: none; sensors are sampled levels, green held MIN_GREEN..MAX_GREEN when contested.
module traffic_ctrl_multi
  import tlc_pkg::*;
#(
  parameter int NUM_DIR    = 2,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 16,
  parameter int YEL_CYC    = 3,
  parameter int ALLRED_CYC = 2,
  parameter int WALK_CYC   = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_DIR-1:0]         tsens,
  output logic [2*NUM_DIR-1:0]       lights,
  output logic [1:0]                 phase,
  output logic [$clog2(NUM_DIR)-1:0] cur_dir
`ifdef TLC_PED_EN
  ,
  input  logic                       ped_req,
  output logic                       walk
`endif
);

  localparam int CW = $clog2(NUM_DIR);
  localparam int TW = $clog2(MAX_GREEN + 1);

  localparam logic [TW-1:0]      T_MIN    = TW'(MIN_GREEN - 1);
  localparam logic [TW-1:0]      T_MAX    = TW'(MAX_GREEN - 1);
  localparam logic [TW-1:0]      T_YEL    = TW'(YEL_CYC - 1);
  localparam logic [TW-1:0]      T_ALLRED = TW'((ALLRED_CYC > 0) ? ALLRED_CYC - 1 : 0);
  localparam logic [TW-1:0]      T_WALK   = TW'(WALK_CYC - 1);
  localparam logic [NUM_DIR-1:0] ONE      = NUM_DIR'(1);

  phase_e          phase_q, phase_d;
  logic [CW-1:0]   cur_q, cur_d, nxt_q, nxt_d, nxt_ok;
  logic [TW-1:0]   timer;
  logic            ped_pend;
  logic            other_req, dir_bad, nxt_bad;

  tlc_phase_timer #(
    .W   (TW),
    .SAT (MAX_GREEN - 1)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (phase_d != phase_q),
    .cnt     (timer)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= PH_GREEN;
      cur_q   <= '0;
      nxt_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
    end
  end

`ifdef TLC_PED_EN
  // Sticky until walk is entered; a request during walk re-arms for the next round.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ped_pend <= 1'b0;
    end else begin
      ped_pend <= ped_req | (ped_pend & ~((phase_d == PH_WALK) && (phase_q != PH_WALK)));
    end
  end
  assign walk = (phase_q == PH_WALK);
`else
  assign ped_pend = 1'b0;
`endif

  assign dir_bad   = (32'(cur_q) >= NUM_DIR);
  assign nxt_bad   = (32'(nxt_q) >= NUM_DIR);
  assign nxt_ok    = nxt_bad ? '0 : nxt_q;
  assign other_req = (|(tsens & ~(ONE << cur_q))) | ped_pend;

  always_comb begin
    phase_d = phase_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    if (dir_bad) begin
      phase_d = PH_ALLRED;
    end else begin
      case (phase_q)
        PH_GREEN: begin
          if (timer >= T_MIN && other_req && (!tsens[cur_q] || timer == T_MAX)) begin
            phase_d = PH_YELLOW;
            nxt_d   = CW'(rr_next(8'(tsens), 3'(cur_q), NUM_DIR));
          end
        end
        PH_YELLOW: begin
          if (timer == T_YEL) begin
            if (ALLRED_CYC > 0) begin
              phase_d = PH_ALLRED;
            end else if (ped_pend) begin
              phase_d = PH_WALK;
            end else begin
              phase_d = PH_GREEN;
              cur_d   = nxt_ok;
            end
          end
        end
        PH_ALLRED: begin
          // Also the landing phase after an illegal state, so timer may be anywhere.
          if (timer >= T_ALLRED) begin
            if (ped_pend) begin
              phase_d = PH_WALK;
            end else begin
              phase_d = PH_GREEN;
              cur_d   = nxt_ok;
            end
          end
        end
        PH_WALK: begin
`ifdef TLC_PED_EN
          if (timer == T_WALK) begin
            phase_d = PH_GREEN;
            cur_d   = nxt_ok;
          end
`else
          phase_d = PH_ALLRED;
`endif
        end
        default: phase_d = PH_ALLRED;
      endcase
    end
  end

  always_comb begin
    lights = {NUM_DIR{LAMP_RED}};
    if (!dir_bad) begin
      for (int i = 0; i < NUM_DIR; i++) begin
        if (32'(cur_q) == i) begin
          if (phase_q == PH_GREEN) begin
            lights[2*i +: 2] = LAMP_GREEN;
          end else if (phase_q == PH_YELLOW) begin
            lights[2*i +: 2] = LAMP_YELLOW;
          end
        end
      end
    end
  end

  assign phase   = phase_q;
  assign cur_dir = cur_q;

endmodule

// File: tb/tb_traffic_ctrl_multi.sv
// Directed bench for traffic_ctrl_multi: a 2-way and a 4-way instance share clock and reset.
// Stimulus queues hand-computed per-cycle expectations; a negedge monitor pops and compares.
module tb_traffic_ctrl_multi;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] tsens2;
  logic [3:0] tsens4;
  logic [3:0] lights2;
  logic [7:0] lights4;
  logic [1:0] phase2, phase4;
  logic [0:0] cur2;
  logic [1:0] cur4;
`ifdef TLC_PED_EN
  logic       ped2 = 1'b0, ped4 = 1'b0;
  logic       walk2, walk4;
`endif

  always #5 clk = ~clk;

  traffic_ctrl_multi #(.NUM_DIR(2)) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .tsens   (tsens2),
    .lights  (lights2),
    .phase   (phase2),
    .cur_dir (cur2)
`ifdef TLC_PED_EN
    ,
    .ped_req (ped2),
    .walk    (walk2)
`endif
  );

  traffic_ctrl_multi #(.NUM_DIR(4)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .tsens   (tsens4),
    .lights  (lights4),
    .phase   (phase4),
    .cur_dir (cur4)
`ifdef TLC_PED_EN
    ,
    .ped_req (ped4),
    .walk    (walk4)
`endif
  );

  typedef struct {
    bit         sel;
    logic [7:0] l;
    logic [1:0] ph;
    logic [2:0] cd;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  // Each call covers n cycles: one expectation per post-edge window.
  task automatic seg(input bit sel, input logic [7:0] l, input logic [1:0] ph,
                     input logic [2:0] cd, input int n, input string tag);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.sel = sel; e.l = l; e.ph = ph; e.cd = cd; e.tag = tag;
      q.push_back(e);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input bit sel);
    reset_n = 1'b0;
    seg(sel, sel ? 8'b10101000 : 8'b00001000, 2'd0, 3'd0, 1, "reset");
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] al;
    logic [1:0] ap;
    logic [2:0] ac;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.sel) begin
        al = lights4; ap = phase4; ac = {1'b0, cur4};
      end else begin
        al = {4'b0000, lights2}; ap = phase2; ac = {2'b00, cur2};
      end
      vectors++;
      if ({al, ap, ac} !== {e.l, e.ph, e.cd}) begin
        miscompares++;
        $display("FAIL %s: got lights=%b phase=%0d cur_dir=%0d, expected lights=%b phase=%0d cur_dir=%0d",
                 e.tag, al, ap, ac, e.l, e.ph, e.cd);
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    tsens2  = 2'b00;
    tsens4  = 4'b0000;
    @(posedge clk);
    #1;

    // Idle: dir0 rests green.
    do_reset(0);
    seg(0, 8'b00001000, 2'd0, 3'd0, 50, "idle_green");

    // Single competing request: min green, yellow, all-red, then dir1 rests.
    tsens2 = 2'b10;
    do_reset(0);
    seg(0, 8'b00001000, 2'd0, 3'd0, 4,  "t2_green0");
    seg(0, 8'b00001001, 2'd1, 3'd0, 3,  "t2_yellow0");
    seg(0, 8'b00001010, 2'd2, 3'd0, 2,  "t2_allred");
    seg(0, 8'b00000010, 2'd0, 3'd1, 10, "t2_green1");

    // Both requesting: max green and alternation.
    tsens2 = 2'b11;
    do_reset(0);
    seg(0, 8'b00001000, 2'd0, 3'd0, 16, "t3_green0");
    seg(0, 8'b00001001, 2'd1, 3'd0, 3,  "t3_yellow0");
    seg(0, 8'b00001010, 2'd2, 3'd0, 2,  "t3_allred0");
    seg(0, 8'b00000010, 2'd0, 3'd1, 16, "t3_green1");
    seg(0, 8'b00000110, 2'd1, 3'd1, 3,  "t3_yellow1");
    seg(0, 8'b00001010, 2'd2, 3'd1, 2,  "t3_allred1");
    seg(0, 8'b00001000, 2'd0, 3'd0, 5,  "t3_green0b");

    // Request swaps during yellow: latched grant still goes to dir1, then min green back to dir0.
    tsens2 = 2'b10;
    do_reset(0);
    seg(0, 8'b00001000, 2'd0, 3'd0, 4, "latch_green0");
    tsens2 = 2'b01;
    seg(0, 8'b00001001, 2'd1, 3'd0, 3, "latch_yellow0");
    seg(0, 8'b00001010, 2'd2, 3'd0, 2, "latch_allred0");
    seg(0, 8'b00000010, 2'd0, 3'd1, 4, "latch_green1");
    seg(0, 8'b00000110, 2'd1, 3'd1, 3, "latch_yellow1");
    seg(0, 8'b00001010, 2'd2, 3'd1, 2, "latch_allred1");
    seg(0, 8'b00001000, 2'd0, 3'd0, 5, "latch_green0b");

    // Async reset on the second yellow cycle, then a clean replay from timer 0.
    tsens2 = 2'b10;
    do_reset(0);
    seg(0, 8'b00001000, 2'd0, 3'd0, 4, "t5_green0");
    seg(0, 8'b00001001, 2'd1, 3'd0, 1, "t5_yellow0");
    reset_n = 1'b0;
    seg(0, 8'b00001000, 2'd0, 3'd0, 1, "t5_async_reset");
    reset_n = 1'b1;
    seg(0, 8'b00001000, 2'd0, 3'd0, 4, "t5_green0_again");
    seg(0, 8'b00001001, 2'd1, 3'd0, 3, "t5_yellow0_again");
    seg(0, 8'b00001010, 2'd2, 3'd0, 2, "t5_allred");
    seg(0, 8'b00000010, 2'd0, 3'd1, 3, "t5_green1");

    // Four approaches, requests on 1 and 3: grants 1,3,1,3; dir2 never green.
    tsens2 = 2'b00;
    tsens4 = 4'b1010;
    do_reset(1);
    seg(1, 8'b10101000, 2'd0, 3'd0, 4,  "t4_green0");
    seg(1, 8'b10101001, 2'd1, 3'd0, 3,  "t4_yellow0");
    seg(1, 8'b10101010, 2'd2, 3'd0, 2,  "t4_allred0");
    seg(1, 8'b10100010, 2'd0, 3'd1, 16, "t4_green1");
    seg(1, 8'b10100110, 2'd1, 3'd1, 3,  "t4_yellow1");
    seg(1, 8'b10101010, 2'd2, 3'd1, 2,  "t4_allred1");
    seg(1, 8'b00101010, 2'd0, 3'd3, 16, "t4_green3");
    seg(1, 8'b01101010, 2'd1, 3'd3, 3,  "t4_yellow3");
    seg(1, 8'b10101010, 2'd2, 3'd3, 2,  "t4_allred3");
    seg(1, 8'b10100010, 2'd0, 3'd1, 16, "t4_green1b");
    seg(1, 8'b10100110, 2'd1, 3'd1, 3,  "t4_yellow1b");
    seg(1, 8'b10101010, 2'd2, 3'd1, 2,  "t4_allred1b");
    seg(1, 8'b00101010, 2'd0, 3'd3, 4,  "t4_green3b");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
